rf_wb_queue: RTL

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

---
 rtl/rf_wb_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/rf_wb_queue.sv
// Register-file write-back queue: buffers {addr, data} writes, drains them in order when not
// stalled, and forwards the youngest pending data for a matching read address.
module rf_wb_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       stall,
  output logic                       rf_we,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_din,
  input  logic [ADDR_WIDTH-1:0]      byp_raddr,
  output logic                       byp_hit,
  output logic [DATA_WIDTH-1:0]      byp_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic [PtrW-1:0] byp_idx;

  assign empty    = (count_q == '0);
  assign count    = count_q;
  // Full blocks the push even when a pop happens in the same cycle.
  assign in_ready = (count_q < CntW'(DEPTH));
  assign push     = in_valid && in_ready && !rst;
  assign rf_we    = !rst && !empty && !stall;
  assign pop      = rf_we;
  assign rf_waddr = addr_mem_q[rd_ptr_q];
  assign rf_din   = data_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= in_addr;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      byp_idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_mem_q[byp_idx] == byp_raddr)) begin
        byp_hit  = 1'b1;
        byp_data = data_mem_q[byp_idx];
      end
    end
  end

endmodule
